led_fade_pwm: RTL and testbench

- Downstream stage between the on-chip pattern generator (blink-style per-colour on/off levels) and the RGB LED pins.
- Turns each colour's on/off request into a PWM drive with a linear brightness ramp, so colour changes fade smoothly instead of hard-switching.
- Runs on the HFOSC-derived system clock with one PWM engine per channel (R, G, B) and a shared ramp prescaler.

---
 rtl/led_fade_pwm.sv | 112 +++++++++++
 tb/tb_led_fade_pwm.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - three-channel LED PWM driver with linear brightness fade
module led_fade_pwm #(
  parameter int p_pwm_bits   = 8,
  parameter int p_step_bits  = 16,
  parameter bit p_active_low = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_r,
  input  logic i_req_g,
  input  logic i_req_b,
  output logic o_led_r,
  output logic o_led_g,
  output logic o_led_b,
  output logic o_idle
);

  localparam logic [p_pwm_bits-1:0]  max_level = '1;
  localparam logic [p_pwm_bits-1:0]  pwm_one   = {{(p_pwm_bits-1){1'b0}}, 1'b1};
  localparam logic [p_step_bits-1:0] step_one  = {{(p_step_bits-1){1'b0}}, 1'b1};
  localparam logic [2:0]             led_off   = {3{p_active_low}};

  logic [2:0]             req_q;
  logic [p_step_bits-1:0] presc;
  logic                   tick;
  logic [p_pwm_bits-1:0]  pwm_cnt;
  logic                   period_end;
  logic [p_pwm_bits-1:0]  level  [3];
  logic [p_pwm_bits-1:0]  duty   [3];
  logic [p_pwm_bits-1:0]  target [3];
  logic [2:0]             on;
  logic [2:0]             at_target;
  logic [2:0]             led_q;
  logic                   idle_q;

  assign tick       = &presc;
  assign period_end = (pwm_cnt == max_level);

  // Per-channel target, compare and settled flags derived from current state.
  always_comb begin
    on        = '0;
    at_target = '0;
    for (int i = 0; i < 3; i++) begin
      target[i]    = req_q[i] ? max_level : '0;
      on[i]        = (duty[i] == max_level) | (pwm_cnt < duty[i]);
      at_target[i] = (level[i] == target[i]);
    end
  end

  // Register the requests once so targets are clean and aligned to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= {i_req_b, i_req_g, i_req_r};
    end
  end

  // Free-running prescaler and PWM period counter, both wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= presc + step_one;
      pwm_cnt <= pwm_cnt + pwm_one;
    end
  end

  // Step each level one count toward its target on a prescaler tick; the
  // target is always 0 or max, so the level can never wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) level[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (level[i] < target[i]) begin
          level[i] <= level[i] + pwm_one;
        end else if (level[i] > target[i]) begin
          level[i] <= level[i] - pwm_one;
        end
      end
    end
  end

  // Latch duty only at the period boundary so a period never changes mid-way;
  // on a coincident tick this captures the level before its update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) duty[i] <= '0;
    end else if (period_end) begin
      for (int i = 0; i < 3; i++) duty[i] <= level[i];
    end
  end

  // Registered LED drive with polarity applied, plus the settled flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      led_q  <= led_off;
      idle_q <= 1'b1;
    end else begin
      led_q  <= on ^ led_off;
      idle_q <= &at_target;
    end
  end

  assign o_led_r = led_q[0];
  assign o_led_g = led_q[1];
  assign o_led_b = led_q[2];
  assign o_idle  = idle_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb/tb_led_fade_pwm.sv - directed self-checking bench for led_fade_pwm
module tb_led_fade_pwm;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;
  logic rst_n2 = 1'b1;
  logic req_r = 1'b0, req_g = 1'b0, req_b = 1'b0;
  logic req_r2 = 1'b0, req_g2 = 1'b0, req_b2 = 1'b0;
  logic led_r, led_g, led_b, idle;
  logic led_r2, led_g2, led_b2, idle2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  led_fade_pwm #(.p_pwm_bits(4), .p_step_bits(2), .p_active_low(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_r(req_r), .i_req_g(req_g), .i_req_b(req_b),
    .o_led_r(led_r), .o_led_g(led_g), .o_led_b(led_b), .o_idle(idle)
  );

  led_fade_pwm #(.p_pwm_bits(4), .p_step_bits(2), .p_active_low(1'b0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n2),
    .i_req_r(req_r2), .i_req_g(req_g2), .i_req_b(req_b2),
    .o_led_r(led_r2), .o_led_g(led_g2), .o_led_b(led_b2), .o_idle(idle2)
  );

  always #5 if (clk_en) clk = ~clk;

  // Edge count since dut1 reset release; edge n has prescaler phase n%4.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    int guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) chk("goto_timeout", cyc, n);
  endtask

  // Count lit samples after edges first..last for one DUT (lit is polarity-aware).
  task automatic window(input int first, input int last, input bit d2,
                        output int lr, output int lg, output int lb);
    lr = 0; lg = 0; lb = 0;
    for (int c = first; c <= last; c++) begin
      goto(c);
      if (d2) begin
        lr += int'(led_r2); lg += int'(led_g2); lb += int'(led_b2);
      end else begin
        lr += int'(!led_r); lg += int'(!led_g); lb += int'(!led_b);
      end
    end
  endtask

  initial begin
    int lr, lg, lb, bad;

    // Asynchronous reset with the clock stopped.
    #2 rst_n = 1'b0; rst_n2 = 1'b0;
    #2;
    chk("rst_led_r", int'(led_r), 1);
    chk("rst_led_g", int'(led_g), 1);
    chk("rst_led_b", int'(led_b), 1);
    chk("rst_idle", int'(idle), 1);
    chk("rst_led2_r", int'(led_r2), 0);
    chk("rst_idle2", int'(idle2), 1);
    #3 rst_n = 1'b1; rst_n2 = 1'b1; clk_en = 1'b1;

    // Quiet after release with all requests low.
    bad = 0;
    for (int c = 1; c <= 40; c++) begin
      goto(c);
      if (led_r !== 1'b1 || led_g !== 1'b1 || led_b !== 1'b1 || idle !== 1'b1) bad++;
    end
    chk("quiet_after_release", bad, 0);

    // Ramp up red.
    req_r = 1'b1;
    goto(41); chk("up_idle_e41", int'(idle), 1);
    goto(42); chk("up_idle_e42", int'(idle), 0);
    goto(43); chk("up_lvl_e43", int'(dut1.level[0]), 0);
    goto(44); chk("up_lvl_e44", int'(dut1.level[0]), 1);
    goto(47); chk("up_lvl_e47", int'(dut1.level[0]), 1);
    goto(48); chk("up_lvl_e48", int'(dut1.level[0]), 2);
    window(49, 64, 1'b0, lr, lg, lb);
    chk("up_lit_d1", lr, 1); chk("up_g_dark", lg, 0); chk("up_b_dark", lb, 0);
    window(65, 80, 1'b0, lr, lg, lb); chk("up_lit_d5", lr, 5);
    window(81, 96, 1'b0, lr, lg, lb); chk("up_lit_d9", lr, 9);
    goto(100); chk("up_lvl_max", int'(dut1.level[0]), 15); chk("up_idle_e100", int'(idle), 0);
    goto(101); chk("up_idle_e101", int'(idle), 1);
    goto(108); chk("up_lvl_sat", int'(dut1.level[0]), 15);
    window(113, 128, 1'b0, lr, lg, lb); chk("up_lit_full", lr, 16);

    // Ramp down red.
    req_r = 1'b0;
    window(129, 144, 1'b0, lr, lg, lb); chk("dn_lit_d15", lr, 16);
    chk("dn_idle_busy", int'(idle), 0);
    window(145, 160, 1'b0, lr, lg, lb); chk("dn_lit_d12", lr, 12);
    window(161, 176, 1'b0, lr, lg, lb); chk("dn_lit_d8", lr, 8);
    goto(188); chk("dn_lvl_zero", int'(dut1.level[0]), 0); chk("dn_idle_e188", int'(idle), 0);
    goto(189); chk("dn_idle_e189", int'(idle), 1);
    window(193, 208, 1'b0, lr, lg, lb); chk("dn_lit_d0", lr, 0);
    goto(212); chk("dn_lvl_sat0", int'(dut1.level[0]), 0);

    // Green reversal at level 7.
    goto(224); req_g = 1'b1;
    goto(252); chk("rev_lvl7", int'(dut1.level[1]), 7);
    req_g = 1'b0;
    goto(255); chk("rev_hold7", int'(dut1.level[1]), 7);
    goto(256); chk("rev_lvl6", int'(dut1.level[1]), 6);
    goto(260); chk("rev_lvl5", int'(dut1.level[1]), 5);
    goto(284); chk("rev_lvl_floor", int'(dut1.level[1]), 0);
    chk("rev_red_untouched", int'(dut1.level[0]), 0);

    // Red and blue together, green idle.
    goto(290); req_r = 1'b1; req_b = 1'b1;
    bad = 0;
    for (int c = 291; c <= 350; c++) begin
      goto(c);
      if (dut1.level[0] !== dut1.level[2] || led_r !== led_b || led_g !== 1'b1) bad++;
    end
    chk("sim_rb_match", bad, 0);
    chk("sim_lvl_r", int'(dut1.level[0]), 15);
    chk("sim_lvl_b", int'(dut1.level[2]), 15);

    // Active-high instance: ramp all three, reset mid-ramp, then blue only.
    goto(368); req_r2 = 1'b1; req_g2 = 1'b1; req_b2 = 1'b1;
    window(385, 400, 1'b1, lr, lg, lb);
    chk("pol_lit_r", lr, 3); chk("pol_lit_g", lg, 3); chk("pol_lit_b", lb, 3);
    #2 rst_n2 = 1'b0;
    #1;
    chk("mid_rst_led_r2", int'(led_r2), 0);
    chk("mid_rst_led_g2", int'(led_g2), 0);
    chk("mid_rst_led_b2", int'(led_b2), 0);
    chk("mid_rst_idle2", int'(idle2), 1);
    req_r2 = 1'b0; req_g2 = 1'b0;
    goto(404); rst_n2 = 1'b1;
    window(405, 420, 1'b1, lr, lg, lb);
    chk("post_lit_r2", lr, 0); chk("post_lit_g2", lg, 0); chk("post_lit_b2", lb, 0);
    chk("post_lvl_b2", int'(dut2.level[2]), 4);
    chk("post_lvl_r2", int'(dut2.level[0]), 0);
    chk("post_lvl_g2", int'(dut2.level[1]), 0);
    chk("post_idle2", int'(idle2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
